// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the 8x8 sequential shift-add multiplier.
package seq_mult_pkg;

    // Operand width is tied to the external mod-8 iteration counter.
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    // Count value seen at the edge that performs the eighth and final step.
    localparam logic [CNT_W-1:0] LAST_CNT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Multiplier datapath: M, A, Q and carry registers, 9-bit adder, right shifter, product register.
// Build switch SEQ_MULT_SIGNED_EN selects two's-complement operation (sign-extended add,
// arithmetic shift, subtract on the final step); undefined gives plain unsigned shift-add.
module seq_mult_datapath
    import seq_mult_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   step,
    input  logic                   last,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [WIDTH-1:0]       multiplier,
    output logic [2*WIDTH-1:0]     product
);

    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic             c_q;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic             shift_in;

    // One step's add: {C,A} plus the selected multiple of M, kept at 9 bits so no carry is lost.
    always_comb begin
        addend   = '0;
        sum      = '0;
        shift_in = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        if (q_q[0]) begin
            if (last) begin
                addend = {(WIDTH+1){1'b0}} - {m_q[WIDTH-1], m_q};
            end else begin
                addend = {m_q[WIDTH-1], m_q};
            end
        end
        sum      = {c_q, a_q} + addend;
        shift_in = sum[WIDTH];
`else
        if (q_q[0]) begin
            addend = {1'b0, m_q};
        end
        sum      = {c_q, a_q} + addend;
        shift_in = 1'b0;
`endif
    end

    // Operand load on an accepted start, then one add-and-shift per step; the product is captured on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            product <= '0;
        end else if (load) begin
            m_q <= multiplicand;
            q_q <= multiplier;
            a_q <= '0;
            c_q <= 1'b0;
        end else if (step) begin
            a_q <= sum[WIDTH:1];
            q_q <= {sum[0], q_q[WIDTH-1:1]};
            c_q <= shift_in;
            if (last) begin
                product <= {sum, q_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE/RUN/DONE FSM driving the external mod-8
// counter and the datapath. Optional build macro: SEQ_MULT_SIGNED_EN (signed operands).
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [WIDTH-1:0]       Multiplicand,
    input  logic [WIDTH-1:0]       Multiplier,
    input  logic [CNT_W-1:0]       Cnt_Value,
    output logic                   Cnt_En,
    output logic                   Cnt_Clr,
    output logic                   Busy,
    output logic                   Done,
    output logic [2*WIDTH-1:0]     Product
);

    state_t state;
    state_t state_next;
    logic   load;
    logic   step;
    logic   last;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; the counter is held clear whenever no step is running.
    always_comb begin
        state_next = state;
        Cnt_En     = 1'b0;
        Cnt_Clr    = 1'b1;
        Busy       = 1'b0;
        Done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        last       = (Cnt_Value == LAST_CNT);
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                Cnt_En  = 1'b1;
                Cnt_Clr = 1'b0;
                Busy    = 1'b1;
                step    = 1'b1;
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                Busy       = 1'b1;
                Done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    seq_mult_datapath u_datapath (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .load         (load),
        .step         (step),
        .last         (last),
        .multiplicand (Multiplicand),
        .multiplier   (Multiplier),
        .product      (Product)
    );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl wired to a mod-8 iteration counter.
// Honours SEQ_MULT_SIGNED_EN for the expected products.
module tb_seq_mult_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [7:0]  Multiplicand;
    logic [7:0]  Multiplier;
    logic [2:0]  Cnt_Value;
    logic        Cnt_En;
    logic        Cnt_Clr;
    logic        Busy;
    logic        Done;
    logic [15:0] Product;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        logic [7:0] m;
        logic [7:0] q;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
    } vec_t;

    vec_t tbl [6];

    always #5 Clk = ~Clk;

    // Mod-8 iteration counter with synchronous active-high clear.
    always_ff @(posedge Clk) begin
        if (Cnt_Clr) begin
            Cnt_Value <= 3'd0;
        end else if (Cnt_En) begin
            Cnt_Value <= Cnt_Value + 3'd1;
        end
    end

    seq_mult_ctrl dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Cnt_Value    (Cnt_Value),
        .Cnt_En       (Cnt_En),
        .Cnt_Clr      (Cnt_Clr),
        .Busy         (Busy),
        .Done         (Done),
        .Product      (Product)
    );

    // Reference product computed directly from the arithmetic meaning of the operands.
    function automatic logic [15:0] refProduct(input logic [7:0] m, input logic [7:0] q);
        logic signed [15:0] sm;
        logic signed [15:0] sq;
        logic [15:0] r;
`ifdef SEQ_MULT_SIGNED_EN
        sm = $signed({{8{m[7]}}, m});
        sq = $signed({{8{q[7]}}, q});
        r  = 16'(sm * sq);
`else
        sm = $signed({8'd0, m});
        sq = $signed({8'd0, q});
        r  = 16'(sm * sq);
`endif
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present operands with Start for one cycle; returns at the falling edge after the sampling edge.
    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q);
        @(negedge Clk);
        Start        = 1'b1;
        Multiplicand = m;
        Multiplier   = q;
        @(negedge Clk);
        Start        = 1'b0;
        Multiplicand = 8'($urandom);
        Multiplier   = 8'($urandom);
    endtask

    task automatic runOp(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp_p, input string name);
        int lat  = 0;
        int en   = 0;
        bit seen = 1'b0;
        applyStimulus(m, q);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (Cnt_En) en++;
                @(negedge Clk);
                lat++;
            end
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_product"}, 32'(Product), 32'(exp_p));
        checkOutput({name, "_latency"}, lat, 8);
        checkOutput({name, "_en_cycles"}, en, 8);
        checkOutput({name, "_busy_in_done"}, 32'(Busy), 32'd1);
        @(negedge Clk);
        checkOutput({name, "_done_width"}, 32'(Done), 32'd0);
        checkOutput({name, "_idle_busy"}, 32'(Busy), 32'd0);
        checkOutput({name, "_idle_clr"}, 32'(Cnt_Clr), 32'd1);
        checkOutput({name, "_held"}, 32'(Product), 32'(exp_p));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dones;
        int prev;
        int npulse;
        logic [15:0] got;
        logic [7:0] rm;
        logic [7:0] rq;

        tbl[0] = '{"basic",    8'd13,  8'd11,  16'h008F, 16'h008F};
        tbl[1] = '{"max",      8'd255, 8'd255, 16'hFE01, 16'h0001};
        tbl[2] = '{"zero",     8'd0,   8'd200, 16'h0000, 16'h0000};
        tbl[3] = '{"neg3x5",   8'hFD,  8'd5,   16'h04F1, 16'hFFF1};
        tbl[4] = '{"m128sq",   8'h80,  8'h80,  16'h4000, 16'h4000};
        tbl[5] = '{"ones",     8'd1,   8'd1,   16'h0001, 16'h0001};

        Reset_n      = 1'b0;
        Start        = 1'b0;
        Multiplicand = 8'd0;
        Multiplier   = 8'd0;
        #1;
        checkOutput("rst_product", 32'(Product), 32'd0);
        checkOutput("rst_done", 32'(Done), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_cnt_en", 32'(Cnt_En), 32'd0);
        checkOutput("rst_cnt_clr", 32'(Cnt_Clr), 32'd1);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
`ifdef SEQ_MULT_SIGNED_EN
            runOp(tbl[i].m, tbl[i].q, tbl[i].exp_s, tbl[i].name);
`else
            runOp(tbl[i].m, tbl[i].q, tbl[i].exp_u, tbl[i].name);
`endif
        end

        // Start while busy must be ignored.
        applyStimulus(8'd3, 8'd4);
        dones = 0;
        got   = 16'hDEAD;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (i == 3) begin
                Start        = 1'b1;
                Multiplicand = 8'd9;
                Multiplier   = 8'd9;
            end
            if (i == 4) Start = 1'b0;
            if (Done) begin
                dones++;
                got = Product;
            end
        end
        checkOutput("busy_start_pulses", dones, 1);
        checkOutput("busy_start_product", 32'(got), 32'h000C);
        checkOutput("busy_start_held", 32'(Product), 32'h000C);

        // Reset in the middle of an operation aborts it.
        applyStimulus(8'd7, 8'd7);
        repeat (5) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checkOutput("abort_product", 32'(Product), 32'd0);
        checkOutput("abort_busy", 32'(Busy), 32'd0);
        checkOutput("abort_cnt_clr", 32'(Cnt_Clr), 32'd1);
        checkOutput("abort_cnt_en", 32'(Cnt_En), 32'd0);
        checkOutput("abort_done", 32'(Done), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        runOp(8'd2, 8'd3, 16'h0006, "after_abort");

        // Start held high: one result every 10 cycles.
        @(negedge Clk);
        Start        = 1'b1;
        Multiplicand = 8'd5;
        Multiplier   = 8'd6;
        prev   = -1;
        npulse = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (Done) begin
                npulse++;
                checkOutput("b2b_product", 32'(Product), 32'h001E);
                if (prev >= 0) checkOutput("b2b_spacing", i - prev, 10);
                prev = i;
            end
        end
        Start = 1'b0;
        checkOutput("b2b_pulses", npulse, 4);
        repeat (2) @(negedge Clk);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 16; i++) begin
            rm = 8'($urandom_range(0, 255));
            rq = 8'($urandom_range(0, 255));
            runOp(rm, rq, refProduct(rm, rq), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
